// File: rtl/da_mac_seq_if.sv
// Handshake and datapath-control bundle between the DA sequencer, its
// sample source / result sink, and the pre-adder/LUT/accumulator datapath.
// master: the sequencer side. slave: the source/sink/datapath side.
interface da_mac_seq_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             load;
   logic             shift_en;
   logic [CNT_W-1:0] bit_idx;
   logic             acc_clr;
   logic             acc_en;
   logic             acc_sub;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport master (
      input  in_valid, out_ready,
      output in_ready, load, shift_en, bit_idx, acc_clr, acc_en, acc_sub,
             out_valid, busy
   );

   modport slave (
      output in_valid, out_ready,
      input  in_ready, load, shift_en, bit_idx, acc_clr, acc_en, acc_sub,
             out_valid, busy
   );
endinterface

// File: rtl/da_mac_seq.sv
// Sequencer for a bit-serial distributed-arithmetic multiplier.
// Accepts a sample set (valid/ready), strobes the pre-adder capture, waits
// PIPE_LAT cycles, steps the LUT/accumulator through DSIZE+1 bits LSB first
// (sign bit subtracted), then holds the result valid until the sink takes it.
// Optional macro DA_BACK2BACK_EN: accept the next sample set on the same
// edge the result is consumed, skipping the IDLE cycle.
module da_mac_seq #(
   parameter int DSIZE    = 10,
   parameter int PIPE_LAT = 1,
   parameter int CNT_W    = 4
) (
   input logic          clk,
   input logic          rst_n,
   da_mac_seq_if.master bus
);

   localparam int NB = DSIZE + 1;

   if (((2 ** CNT_W) < NB) || (PIPE_LAT < 0) || (PIPE_LAT > (2 ** CNT_W) - 1)) begin : g_param_err
      $error("da_mac_seq: illegal parameters (need 2**CNT_W >= DSIZE+1 and 0 <= PIPE_LAT <= 2**CNT_W-1)");
   end

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NB - 1);
   localparam logic [CNT_W-1:0] LAST_LAT = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] lat_q, lat_d;
   logic [CNT_W-1:0] bit_q, bit_d;
   logic             rdy;
   logic             accept;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lat_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         bit_q   <= bit_d;
      end
   end

   // Input-side handshake: ready depends only on state (and out_ready in DONE)
   always_comb begin
      rdy = 1'b0;
      case (state_q)
         IDLE:    rdy = 1'b1;
`ifdef DA_BACK2BACK_EN
         DONE:    rdy = bus.out_ready;
`endif
         default: rdy = 1'b0;
      endcase
      accept       = bus.in_valid & rdy;
      bus.in_ready = rdy;
      bus.load     = accept;
   end

   // Next-state and counter update
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      bit_d   = bit_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (PIPE_LAT > 0) begin
                  state_d = WAIT;
                  lat_d   = '0;
               end else begin
                  state_d = RUN;
                  bit_d   = '0;
               end
            end
         end
         WAIT: begin
            if (lat_q == LAST_LAT) begin
               state_d = RUN;
               lat_d   = '0;
               bit_d   = '0;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         RUN: begin
            if (bit_q == LAST_BIT) begin
               state_d = DONE;
               bit_d   = '0;
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         DONE: begin
            // A same-edge accept takes priority over returning to IDLE;
            // it can only happen when out_ready is also high.
            if (accept) begin
               if (PIPE_LAT > 0) begin
                  state_d = WAIT;
                  lat_d   = '0;
               end else begin
                  state_d = RUN;
                  bit_d   = '0;
               end
            end else if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore decodes of registered state and bit counter
   always_comb begin
      bus.shift_en  = 1'b0;
      bus.acc_en    = 1'b0;
      bus.acc_clr   = 1'b0;
      bus.acc_sub   = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = (state_q != IDLE);
      bus.bit_idx   = bit_q;
      if (state_q == RUN) begin
         bus.shift_en = 1'b1;
         bus.acc_en   = 1'b1;
         bus.acc_clr  = (bit_q == '0);
         bus.acc_sub  = (bit_q == LAST_BIT);
      end
      if (state_q == DONE) begin
         bus.out_valid = 1'b1;
      end
   end

endmodule

// File: tb/tb_da_mac_seq.sv
// Bench for da_mac_seq: cycle table for a single transaction, hand sequences
// for backpressure / throughput / async reset / a PIPE_LAT=0 instance, and a
// random phase checked against a transaction-timeline model.
module tb_da_mac_seq;

   localparam int PL = 1;
   localparam int NB = 11;
`ifdef DA_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic clk;
   logic rst_n;

   da_mac_seq_if #(.CNT_W(4)) ifc ();
   da_mac_seq_if #(.CNT_W(3)) ifc2 ();

   da_mac_seq #(.DSIZE(10), .PIPE_LAT(1), .CNT_W(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   da_mac_seq #(.DSIZE(4), .PIPE_LAT(0), .CNT_W(3)) dut_small (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Timeline model: cycles elapsed since the accepting edge
   bit m_active = 1'b0;
   int m_t      = 0;

   int s_rdy, s_ld, s_sh, s_idx, s_clr, s_en, s_sub, s_ov, s_busy;

   typedef struct {
      bit iv, ordy, rdy, ld, sh;
      int idx;
      bit clr, en, sub, ov, busy;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic iv, input logic ordy);
      bit run, done;
      int e_rdy, e_ld, e_idx;
      ifc.in_valid  = iv;
      ifc.out_ready = ordy;
      @(negedge clk);
      s_rdy  = int'(ifc.in_ready);
      s_ld   = int'(ifc.load);
      s_sh   = int'(ifc.shift_en);
      s_idx  = int'(ifc.bit_idx);
      s_clr  = int'(ifc.acc_clr);
      s_en   = int'(ifc.acc_en);
      s_sub  = int'(ifc.acc_sub);
      s_ov   = int'(ifc.out_valid);
      s_busy = int'(ifc.busy);
      run   = m_active && (m_t >= PL + 1) && (m_t <= PL + NB);
      done  = m_active && (m_t >= PL + NB + 1);
      e_idx = run ? m_t - PL - 1 : 0;
      e_rdy = !m_active ? 1 : ((done && B2B) ? int'(ordy) : 0);
      e_ld  = e_rdy & int'(iv);
      chk("in_ready", s_rdy, e_rdy);
      chk("load", s_ld, e_ld);
      chk("shift_en", s_sh, int'(run));
      chk("acc_en", s_en, int'(run));
      chk("bit_idx", s_idx, e_idx);
      chk("acc_clr", s_clr, int'(run && e_idx == 0));
      chk("acc_sub", s_sub, int'(run && e_idx == NB - 1));
      chk("out_valid", s_ov, int'(done));
      chk("busy", s_busy, int'(m_active));
      if (e_ld != 0) begin
         m_active = 1'b1;
         m_t      = 1;
      end else if (done && ordy) begin
         m_active = 1'b0;
      end else if (m_active) begin
         m_t++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && m_active; n++) step(1'b0, 1'b1);
      chk("drain_idle", int'(m_active), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int loads[$];
      int start, first_ov, second_acc;

      // Cycle table for one transaction, accept at cycle 0, out_ready=1
      tbl[0]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[2]  = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1};
      for (int i = 3; i <= 11; i++) tbl[i] = '{0, 1, 0, 0, 1, i - 2, 0, 1, 0, 0, 1};
      tbl[12] = '{0, 1, 0, 0, 1, 10, 0, 1, 1, 0, 1};
      tbl[13] = '{0, 1, B2B, 0, 0, 0, 0, 0, 0, 1, 1};
      tbl[14] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

      rst_n          = 1'b0;
      ifc.in_valid   = 1'b0;
      ifc.out_ready  = 1'b0;
      ifc2.in_valid  = 1'b0;
      ifc2.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(ifc.in_ready), 1);
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_out_valid", int'(ifc.out_valid), 0);
      chk("rst_shift_en", int'(ifc.shift_en), 0);
      chk("rst_bit_idx", int'(ifc.bit_idx), 0);
      chk("rst_acc", int'({ifc.acc_clr, ifc.acc_en, ifc.acc_sub}), 0);
      chk("rst_load", int'(ifc.load), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;

      // Single transaction against the table
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].iv, tbl[i].ordy);
         chk("tbl_rdy", s_rdy, int'(tbl[i].rdy));
         chk("tbl_load", s_ld, int'(tbl[i].ld));
         chk("tbl_shift", s_sh, int'(tbl[i].sh));
         chk("tbl_idx", s_idx, tbl[i].idx);
         chk("tbl_clr", s_clr, int'(tbl[i].clr));
         chk("tbl_en", s_en, int'(tbl[i].en));
         chk("tbl_sub", s_sub, int'(tbl[i].sub));
         chk("tbl_ov", s_ov, int'(tbl[i].ov));
         chk("tbl_busy", s_busy, int'(tbl[i].busy));
      end

      // Backpressure: out_ready low cycles 13..17, in_valid held high
      start      = cyc;
      second_acc = -1;
      for (int c = 0; c <= 20; c++) begin
         step(1'b1, !(c >= 13 && c <= 17));
         if (c > 0 && s_ld != 0 && second_acc < 0) second_acc = cyc - 1 - start;
      end
      chk("bp_second_accept", second_acc, B2B ? 18 : 19);
      drain();

      // Throughput with in_valid and out_ready held high
      start = cyc;
      for (int c = 0; c < 30; c++) begin
         step(1'b1, 1'b1);
         if (s_ld != 0) loads.push_back(cyc - 1 - start);
      end
      chk("tp_count", loads.size(), 3);
      for (int k = 0; k < 3; k++) begin
         chk("tp_accept_cycle", (k < loads.size()) ? loads[k] : -1, k * (B2B ? 13 : 14));
      end
      drain();

      // Asynchronous reset while bit_idx=5
      step(1'b1, 1'b1);
      for (int c = 0; c < 6; c++) step(1'b0, 1'b1);
      ifc.in_valid = 1'b0;
      #2;
      chk("ar_pre_idx", int'(ifc.bit_idx), 5);
      rst_n = 1'b0;
      #1;
      chk("ar_busy", int'(ifc.busy), 0);
      chk("ar_shift_en", int'(ifc.shift_en), 0);
      chk("ar_bit_idx", int'(ifc.bit_idx), 0);
      chk("ar_acc_en", int'(ifc.acc_en), 0);
      chk("ar_out_valid", int'(ifc.out_valid), 0);
      chk("ar_in_ready", int'(ifc.in_ready), 1);
      @(negedge clk);
      rst_n    = 1'b1;
      m_active = 1'b0;
      @(posedge clk);
      #1;
      start    = cyc;
      first_ov = -1;
      step(1'b1, 1'b1);
      for (int c = 1; c <= 20 && first_ov < 0; c++) begin
         step(1'b0, 1'b1);
         if (s_ov != 0) first_ov = cyc - 1 - start;
      end
      chk("ar_fresh_ov_latency", first_ov, 13);
      drain();

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         step(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 3) != 0));
      end
      drain();

      // PIPE_LAT=0, DSIZE=4 instance: RUN cycles 1..5, out_valid at 6
      ifc.in_valid = 1'b0;
      for (int c = 0; c <= 7; c++) begin
         ifc2.in_valid = (c == 0);
         @(negedge clk);
         chk("s_load", int'(ifc2.load), int'(c == 0));
         chk("s_shift_en", int'(ifc2.shift_en), int'(c >= 1 && c <= 5));
         chk("s_bit_idx", int'(ifc2.bit_idx), (c >= 1 && c <= 5) ? c - 1 : 0);
         chk("s_acc_clr", int'(ifc2.acc_clr), int'(c == 1));
         chk("s_acc_sub", int'(ifc2.acc_sub), int'(c == 5));
         chk("s_out_valid", int'(ifc2.out_valid), int'(c == 6));
         chk("s_busy", int'(ifc2.busy), int'(c >= 1 && c <= 6));
         @(posedge clk);
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
